// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN control FSM and the IF/ID pipeline register.
// Optional macro IF_MISALIGN_CHECK_EN aligns redirect targets and flags the first fetch from them.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
`ifdef IF_MISALIGN_CHECK_EN
  output logic        ifid_misalign,
`endif
  output logic        ifid_valid
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] target;

`ifdef IF_MISALIGN_CHECK_EN
  // pc_mis_reg tags the current PC as having come from a misaligned target.
  logic pc_mis_reg, pc_mis_next;
  logic ifid_mis_reg, ifid_mis_next;
  logic target_mis;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign target_mis = |redirect_pc[1:0];
`else
  assign target = redirect_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= BOOT;
      pc_reg            <= RESET_PC;
      ifid_pc_reg       <= 32'h0;
      ifid_pc_plus4_reg <= 32'h0;
      ifid_instr_reg    <= NOP_INSTR;
      ifid_valid_reg    <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      pc_mis_reg        <= 1'b0;
      ifid_mis_reg      <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      ifid_pc_reg       <= ifid_pc_next;
      ifid_pc_plus4_reg <= ifid_pc_plus4_next;
      ifid_instr_reg    <= ifid_instr_next;
      ifid_valid_reg    <= ifid_valid_next;
`ifdef IF_MISALIGN_CHECK_EN
      pc_mis_reg        <= pc_mis_next;
      ifid_mis_reg      <= ifid_mis_next;
`endif
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    ifid_pc_next       = ifid_pc_reg;
    ifid_pc_plus4_next = ifid_pc_plus4_reg;
    ifid_instr_next    = ifid_instr_reg;
    ifid_valid_next    = ifid_valid_reg;
`ifdef IF_MISALIGN_CHECK_EN
    pc_mis_next        = pc_mis_reg;
    ifid_mis_next      = ifid_mis_reg;
`endif

    case (state_reg)
      BOOT: begin
        state_next         = RUN;
        ifid_pc_next       = 32'h0;
        ifid_pc_plus4_next = 32'h0;
        ifid_instr_next    = NOP_INSTR;
        ifid_valid_next    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        ifid_mis_next      = 1'b0;
`endif
        if (redirect) begin
          pc_next = target;
`ifdef IF_MISALIGN_CHECK_EN
          pc_mis_next = target_mis;
`endif
        end
      end

      default: begin
        // IF/ID: bubble on redirect/flush, hold on stall, otherwise capture.
        if (redirect || flush) begin
          ifid_pc_next       = 32'h0;
          ifid_pc_plus4_next = 32'h0;
          ifid_instr_next    = NOP_INSTR;
          ifid_valid_next    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
          ifid_mis_next      = 1'b0;
`endif
        end else if (!stall) begin
          ifid_pc_next       = pc_reg;
          ifid_pc_plus4_next = pc_plus4;
          ifid_instr_next    = imem_rdata;
          ifid_valid_next    = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
          ifid_mis_next      = pc_mis_reg;
`endif
        end

        if (redirect) begin
          pc_next = target;
`ifdef IF_MISALIGN_CHECK_EN
          pc_mis_next = target_mis;
`endif
        end else if (!stall) begin
          pc_next = pc_plus4;
`ifdef IF_MISALIGN_CHECK_EN
          pc_mis_next = 1'b0;
`endif
        end
      end
    endcase
  end

  assign pc            = pc_reg;
  assign ifid_pc       = ifid_pc_reg;
  assign ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign ifid_instr    = ifid_instr_reg;
  assign ifid_valid    = ifid_valid_reg;
`ifdef IF_MISALIGN_CHECK_EN
  assign ifid_misalign = ifid_mis_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors followed by randomized control traffic
// compared against a rule-level fetch model. Honours IF_MISALIGN_CHECK_EN when defined.
module tb_if_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc, pc_plus4, imem_rdata;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic        ifid_valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic        ifid_misalign;
`endif
  logic [31:0] mem_xor = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: fetch address plus what IF/ID should hold.
  logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
  logic        m_boot, m_valid, m_tag, m_mis;

  always #5 clk = ~clk;

  // External adder and instruction memory (word = address ^ mem_xor).
  assign pc_plus4   = pc + 32'd4;
  assign imem_rdata = pc ^ mem_xor;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .pc_plus4(pc_plus4), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
`ifdef IF_MISALIGN_CHECK_EN
    .ifid_misalign(ifid_misalign),
`endif
    .ifid_valid(ifid_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bubble_model();
    m_valid = 1'b0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = NOP_INSTR; m_mis = 1'b0;
  endtask

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef IF_MISALIGN_CHECK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  // One clock: apply inputs, advance the model by the fetch rules, compare everything.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic rd, input logic [31:0] rpc);
    rst = r; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    if (r) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_tag = 1'b0;
      bubble_model();
    end else if (m_boot) begin
      m_boot = 1'b0;
      bubble_model();
      if (rd) begin m_pc = eff_target(rpc); m_tag = (rpc[1:0] != 2'b00); end
    end else begin
      if (rd || fl) bubble_model();
      else if (!st) begin
        m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_instr = m_pc ^ mem_xor;
        m_valid = 1'b1; m_mis = m_tag;
      end
      if (rd) begin m_pc = eff_target(rpc); m_tag = (rpc[1:0] != 2'b00); end
      else if (!st) begin m_pc = m_pc + 32'd4; m_tag = 1'b0; end
    end
    @(posedge clk);
    #1;
    $display("cyc rst=%0b st=%0b fl=%0b rd=%0b rpc=%08h | pc=%08h ifid_pc=%08h p4=%08h ins=%08h v=%0b",
             r, st, fl, rd, rpc, pc, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid);
    check("pc", pc, m_pc);
    check("ifid_pc", ifid_pc, m_ipc);
    check("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
`ifdef IF_MISALIGN_CHECK_EN
    check("ifid_misalign", {31'h0, ifid_misalign}, {31'h0, m_mis});
`endif
  endtask

  initial begin
    m_pc = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = NOP_INSTR;
    m_boot = 1'b1; m_valid = 1'b0; m_tag = 1'b0; m_mis = 1'b0;

    // Reset for two cycles, then the BOOT cycle, then first fetch.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, NOP_INSTR);
    step(0, 0, 0, 0, 0);
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'h0, ifid_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    check("run1_pc", pc, 32'h4);
    check("run1_ifid_pc", ifid_pc, 32'h0);
    check("run1_valid", {31'h0, ifid_valid}, 32'h1);

    // Straight-line fetch to pc=0x10.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("line_pc", pc, 32'h10);
    check("line_ifid_pc", ifid_pc, 32'hC);
    check("line_instr", ifid_instr, 32'hC);
    check("line_p4", ifid_pc_plus4, 32'h10);

    // Stall three cycles at pc=0x8, then resume.
    step(0, 0, 0, 1, 32'h8);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      check("stall_pc", pc, 32'h10);
      check("stall_ifid_pc", ifid_pc, 32'hC);
    end
    step(0, 0, 0, 1, 32'h8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check("stall8_pc", pc, 32'h8);
    step(0, 0, 0, 0, 0);
    check("resume_pc", pc, 32'hC);
    check("resume_ifid_pc", ifid_pc, 32'h8);

    // Redirect with stall at pc=0x8.
    step(0, 0, 0, 1, 32'h8);
    step(0, 1, 0, 1, 32'h100);
    check("rdst_pc", pc, 32'h100);
    check("rdst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rdst_instr", ifid_instr, NOP_INSTR);
    step(0, 0, 0, 0, 0);
    check("rdst_ifid_pc", ifid_pc, 32'h100);

    // Flush with stall: PC holds, IF/ID bubbles.
    step(0, 1, 1, 0, 0);
    check("flst_pc", pc, 32'h104);
    check("flst_valid", {31'h0, ifid_valid}, 32'h0);

    // Wrap-around from the adder.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("wrap_p4", ifid_pc_plus4, 32'h0);

`ifdef IF_MISALIGN_CHECK_EN
    step(0, 0, 0, 1, 32'h102);
    check("mis_pc", pc, 32'h100);
    step(0, 0, 0, 0, 0);
    check("mis_set", {31'h0, ifid_misalign}, 32'h1);
    step(0, 0, 0, 0, 0);
    check("mis_clr", {31'h0, ifid_misalign}, 32'h0);
`endif

    // Reset during a stall.
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 32'h200);
    check("rst_stall_pc", pc, RESET_PC);
    check("rst_stall_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_stall_ifid_pc", ifid_pc, 32'h0);

    // Redirect accepted in BOOT.
    step(0, 0, 0, 1, 32'h40);
    check("boot_rd_pc", pc, 32'h40);
    step(0, 0, 0, 0, 0);
    check("boot_rd_ifid_pc", ifid_pc, 32'h40);

    // Randomized control traffic.
    mem_xor = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic        r, st, fl, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(r, st, fl, rd, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
